idelay_eye_scan_ctrl: RTL

- Per-lane IDELAY tap calibration sequencer. It sits above NUM_LANES delay_reset_seq instances and their training-pattern checkers.
- For each lane in turn it sweeps the tap value and counts checker errors at each tap. It finds the widest error-free run of taps, then loads the centre of that run.
- Lanes are calibrated strictly one at a time. Lanes not being calibrated keep their tap value unchanged.

---
 rtl/idelay_cal_pkg.sv | 28 ++
 rtl/idelay_eye_scan_ctrl_run_tracker.sv | 91 +++++++++
 rtl/idelay_eye_scan_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/idelay_cal_pkg.sv
// Shared types for the IDELAY eye-scan calibration sequencer.
// Tap width, tap type, sequencer state encoding and the tap-midpoint helper.
package idelay_cal_pkg;

   localparam int TAP_W = 9;

   typedef logic [TAP_W-1:0] tap_t;

   typedef enum logic [3:0] {
      IDLE,
      SET_TAP,
      WAIT_RDY,
      MEASURE,
      EVAL,
      CENTER,
      WAIT_FINAL,
      NEXT_LANE,
      DONE
   } state_t;

   // floor((a+b)/2) with a carry bit so the sum cannot wrap
   function automatic tap_t tap_mid(input tap_t a, input tap_t b);
      logic [TAP_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[TAP_W:1];
   endfunction

endpackage

// File: rtl/idelay_eye_scan_ctrl_run_tracker.sv
// Open-run / best-run bookkeeping for one tap sweep.
// Widest passing run wins; a tie keeps the run found first.
module eye_run_tracker
   import idelay_cal_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic valid,
   input  logic pass,
   input  tap_t tap,
   input  logic flush,
   output logic best_valid,
   output tap_t best_first,
   output tap_t best_last
);

   logic open_q, open_d;
   tap_t first_q, first_d;
   tap_t last_q, last_d;
   logic bv_q, bv_d;
   tap_t bf_q, bf_d;
   tap_t bl_q, bl_d;

   logic eff_open;
   tap_t eff_first;
   tap_t eff_last;
   logic close_run;
   tap_t run_w;
   tap_t best_w;

   // fold the current tap into the open run, then close and rank it if needed
   always_comb begin
      eff_open  = open_q;
      eff_first = first_q;
      eff_last  = last_q;
      if (valid && pass) begin
         if (!open_q) begin
            eff_first = tap;
         end
         eff_last = tap;
         eff_open = 1'b1;
      end
      close_run = eff_open && ((valid && !pass) || flush);
      run_w     = eff_last - eff_first;
      best_w    = bl_q - bf_q;
      open_d    = eff_open && !close_run;
      first_d   = eff_first;
      last_d    = eff_last;
      bv_d      = bv_q;
      bf_d      = bf_q;
      bl_d      = bl_q;
      if (close_run && (!bv_q || (run_w > best_w))) begin
         bv_d = 1'b1;
         bf_d = eff_first;
         bl_d = eff_last;
      end
      if (clr) begin
         open_d  = 1'b0;
         first_d = '0;
         last_d  = '0;
         bv_d    = 1'b0;
         bf_d    = '0;
         bl_d    = '0;
      end
   end

   // tracker registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         open_q  <= 1'b0;
         first_q <= '0;
         last_q  <= '0;
         bv_q    <= 1'b0;
         bf_q    <= '0;
         bl_q    <= '0;
      end else begin
         open_q  <= open_d;
         first_q <= first_d;
         last_q  <= last_d;
         bv_q    <= bv_d;
         bf_q    <= bf_d;
         bl_q    <= bl_d;
      end
   end

   assign best_valid = bv_q;
   assign best_first = bf_q;
   assign best_last  = bl_q;

endmodule

// File: rtl/idelay_eye_scan_ctrl.sv
// Per-lane IDELAY tap calibration: sweep taps, count checker errors,
// and park each lane at the centre of its widest error-free run.
module idelay_eye_scan_ctrl
   import idelay_cal_pkg::*;
#(
   parameter int NUM_LANES    = 4,
   parameter int TAP_MAX      = 511,
   parameter int TAP_STEP     = 8,
   parameter int WINDOW       = 1024,
   parameter int DONE_TIMEOUT = 256,
   parameter int TAP_DEFAULT  = 0,
   localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [NUM_LANES-1:0]       dly_done,
   input  logic [NUM_LANES-1:0]       err,
   output logic [TAP_W*NUM_LANES-1:0] load_value,
   output logic                       busy,
   output logic                       cal_done,
   output logic [NUM_LANES-1:0]       lane_fail,
   output logic [LANE_W-1:0]          cur_lane
);

   localparam int TIMER_W = $clog2(DONE_TIMEOUT + 1);
   localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;

   localparam logic [TIMER_W-1:0] TMO      = TIMER_W'(DONE_TIMEOUT);
   localparam logic [TIMER_W-1:0] BLANK    = TIMER_W'(2);
   localparam logic [WIN_W-1:0]   WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [LANE_W-1:0]  LANE_END = LANE_W'(NUM_LANES - 1);
   localparam logic [TAP_W:0]     STEP_X   = (TAP_W+1)'(TAP_STEP);
   localparam logic [TAP_W:0]     MAX_X    = (TAP_W+1)'(TAP_MAX);
   localparam tap_t               TAP_DEF  = tap_t'(TAP_DEFAULT);

   state_t state_q, state_d;
   logic [LANE_W-1:0] lane_q, lane_d;
   tap_t tap_q, tap_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [WIN_W-1:0] win_q, win_d;
   logic [15:0] err_cnt_q, err_cnt_d;
   tap_t [NUM_LANES-1:0] load_q, load_d;
   logic [NUM_LANES-1:0] fail_q, fail_d;
   logic cal_done_q, cal_done_d;

   logic trk_clr;
   logic trk_valid;
   logic trk_flush;
   logic best_valid;
   tap_t best_first;
   tap_t best_last;
   logic [TAP_W:0] tap_nxt;
   logic lane_rdy;

   eye_run_tracker u_trk (
      .clk        (clk),
      .rst        (rst),
      .clr        (trk_clr),
      .valid      (trk_valid),
      .pass       (err_cnt_q == 16'd0),
      .tap        (tap_q),
      .flush      (trk_flush),
      .best_valid (best_valid),
      .best_first (best_first),
      .best_last  (best_last)
   );

   assign tap_nxt  = {1'b0, tap_q} + STEP_X;
   assign lane_rdy = (timer_q >= BLANK) && dly_done[lane_q];

   // sequencer next-state and datapath updates
   always_comb begin
      state_d    = state_q;
      lane_d     = lane_q;
      tap_d      = tap_q;
      timer_d    = timer_q;
      win_d      = win_q;
      err_cnt_d  = err_cnt_q;
      load_d     = load_q;
      fail_d     = fail_q;
      cal_done_d = cal_done_q;
      trk_clr    = 1'b0;
      trk_valid  = 1'b0;
      trk_flush  = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               cal_done_d = 1'b0;
               fail_d     = '0;
               lane_d     = '0;
               tap_d      = '0;
               trk_clr    = 1'b1;
               state_d    = SET_TAP;
            end
         end
         SET_TAP: begin
            load_d[lane_q] = tap_q;
            timer_d        = '0;
            state_d        = WAIT_RDY;
         end
         WAIT_RDY: begin
            if (lane_rdy) begin
               err_cnt_d = '0;
               win_d     = '0;
               state_d   = MEASURE;
            end else if (timer_q >= TMO) begin
               fail_d[lane_q] = 1'b1;
               load_d[lane_q] = TAP_DEF;
               state_d        = NEXT_LANE;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         MEASURE: begin
            if (err[lane_q] && (err_cnt_q != 16'hFFFF)) begin
               err_cnt_d = err_cnt_q + 16'd1;
            end
            win_d = win_q + WIN_W'(1);
            if (win_q == WIN_LAST) begin
               state_d = EVAL;
            end
         end
         EVAL: begin
            trk_valid = 1'b1;
            if (tap_nxt > MAX_X) begin
               trk_flush = 1'b1;
               state_d   = CENTER;
            end else begin
               tap_d   = tap_nxt[TAP_W-1:0];
               state_d = SET_TAP;
            end
         end
         CENTER: begin
            if (best_valid) begin
               load_d[lane_q] = tap_mid(best_first, best_last);
            end else begin
               fail_d[lane_q] = 1'b1;
               load_d[lane_q] = TAP_DEF;
            end
            timer_d = '0;
            state_d = WAIT_FINAL;
         end
         WAIT_FINAL: begin
            if (lane_rdy) begin
               state_d = NEXT_LANE;
            end else if (timer_q >= TMO) begin
               fail_d[lane_q] = 1'b1;
               state_d        = NEXT_LANE;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         NEXT_LANE: begin
            if (lane_q == LANE_END) begin
               cal_done_d = 1'b1;
               state_d    = DONE;
            end else begin
               lane_d  = lane_q + LANE_W'(1);
               tap_d   = '0;
               trk_clr = 1'b1;
               state_d = SET_TAP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // sequencer state and per-lane outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         lane_q     <= '0;
         tap_q      <= '0;
         timer_q    <= '0;
         win_q      <= '0;
         err_cnt_q  <= '0;
         load_q     <= {NUM_LANES{TAP_DEF}};
         fail_q     <= '0;
         cal_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         tap_q      <= tap_d;
         timer_q    <= timer_d;
         win_q      <= win_d;
         err_cnt_q  <= err_cnt_d;
         load_q     <= load_d;
         fail_q     <= fail_d;
         cal_done_q <= cal_done_d;
      end
   end

   assign load_value = load_q;
   assign busy       = (state_q != IDLE) && (state_q != DONE);
   assign cal_done   = cal_done_q;
   assign lane_fail  = fail_q;
   assign cur_lane   = lane_q;

endmodule
